// File: rtl/key_pkg.sv
// Shared types and constants for the block-game key debouncer.
// KEY_AUTO_REPEAT_EN (see key_db_chan) enables held-key auto-repeat.
package key_pkg;

  typedef enum logic {
    KEY_RELEASED = 1'b0,
    KEY_PRESSED  = 1'b1
  } key_state_e;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;
  localparam int KEY_DROP  = 3;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEF_CLK_FREQ_HZ  = 50_000_000;
  localparam int DB_CNT           = ms_to_cycles(DEF_CLK_FREQ_HZ, 20);
  localparam int REPEAT_DELAY_CNT = ms_to_cycles(DEF_CLK_FREQ_HZ, 400);
  localparam int REPEAT_RATE_CNT  = ms_to_cycles(DEF_CLK_FREQ_HZ, 100);

endpackage

// File: rtl/key_db_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, RELEASED/PRESSED FSM.
// Define KEY_AUTO_REPEAT_EN to add periodic press strobes while a key is held.
module key_db_chan
  import key_pkg::*;
#(
  parameter int CNT_W    = 21,
  parameter int DB_CNT   = 16,
  parameter int RPT_DLY  = 64,
  parameter int RPT_RATE = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_n_i,
  output key_state_e state_o,
  output logic       press_o,
  output logic       press_d_o,
  output logic       release_o
);

  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DB_CNT - 1);

  if (RPT_DLY < 1 || RPT_RATE < 1) begin : g_bad_rpt
    $error("key_db_chan: repeat delay and rate must be at least one cycle");
  end

  logic [1:0]       sync_q;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             lvl_mismatch;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int             RPT_W     = $clog2(RPT_DLY + RPT_RATE + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(RPT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(RPT_DLY + RPT_RATE - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  // Pin is active-low; compare the synchronised "pressed" sense with the state.
  assign lvl_mismatch = (~sync_q[1]) != (state_q == KEY_PRESSED);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (!lvl_mismatch) begin
      cnt_d = '0;
    end else if (cnt_q >= DB_TERM) begin
      cnt_d = '0;
      if (state_q == KEY_RELEASED) begin
        state_d = KEY_PRESSED;
        press_d = 1'b1;
      end else begin
        state_d   = KEY_RELEASED;
        release_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef KEY_AUTO_REPEAT_EN
    // Counts cycles spent in PRESSED; after the first repeat it loops over one rate period.
    rpt_d = rpt_q;
    if (state_q != KEY_PRESSED || state_d != KEY_PRESSED) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_LAST) begin
      rpt_d   = RPT_W'(RPT_DLY);
      press_d = 1'b1;
    end else begin
      if (rpt_q == RPT_FIRST) press_d = 1'b1;
      rpt_d = rpt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= KEY_RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_AUTO_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign press_d_o = press_d;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer feeding the game control FSM.
// Build with KEY_AUTO_REPEAT_EN defined to get auto-repeat press strobes.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int CNT_W           = 21,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_any
);

  localparam int DB_CYC       = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int RPT_DLY_CYC  = ms_to_cycles(CLK_FREQ_HZ, REPEAT_DELAY_MS);
  localparam int RPT_RATE_CYC = ms_to_cycles(CLK_FREQ_HZ, REPEAT_RATE_MS);

  if (DB_CYC < 1 || longint'(DB_CYC) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_w
    $error("key_debounce_multi: CNT_W too small for the debounce window");
  end

  key_state_e          chan_state [NUM_KEYS];
  logic [NUM_KEYS-1:0] press_nxt;
  logic                key_any_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_db_chan #(
      .CNT_W   (CNT_W),
      .DB_CNT  (DB_CYC),
      .RPT_DLY (RPT_DLY_CYC),
      .RPT_RATE(RPT_RATE_CYC)
    ) u_chan (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_n_i  (key_in[i]),
      .state_o  (chan_state[i]),
      .press_o  (key_press[i]),
      .press_d_o(press_nxt[i]),
      .release_o(key_release[i])
    );
    assign key_level[i] = (chan_state[i] == KEY_PRESSED);
  end

  // Registered from the channels' next-press terms so it lines up with key_press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) key_any_q <= 1'b0;
    else            key_any_q <= |press_nxt;
  end

  assign key_any = key_any_q;

endmodule
